// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared FSM encoding, key indices and sizing helpers for the key conditioner
package key_pkg;

  // Per-channel conditioner states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PDEB = 3'd1,
    HELD = 3'd2,
    RPT  = 3'd3,
    RDEB = 3'd4
  } key_fsm_e;

  // Default key-to-channel map of the clock front panel
  localparam int KEY_DISP  = 0;
  localparam int KEY_MODE  = 1;
  localparam int KEY_SHIFT = 2;
  localparam int KEY_INC   = 3;
  localparam int KEY_DEC   = 4;
  localparam int KEY_RUN   = 5;
  localparam int KEY_CLR   = 6;

  // Bits needed to hold 0..value-1, never less than 1
  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return (res < 1) ? 1 : res;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_filter_rpt_if.sv
// rtl/key_filter_rpt_if.sv - raw key inputs and conditioned event outputs of the key conditioner
interface key_filter_rpt_if #(
  parameter int KEY_NUM = 7
);
  logic [KEY_NUM-1:0] key_in;
  logic [KEY_NUM-1:0] key_state;
  logic [KEY_NUM-1:0] key_press;
  logic [KEY_NUM-1:0] key_release;
  logic [KEY_NUM-1:0] key_repeat;

  // Panel / stimulus side: drives raw keys, consumes events
  modport master (
    output key_in,
    input  key_state,
    input  key_press,
    input  key_release,
    input  key_repeat
  );

  // Conditioner side
  modport slave (
    input  key_in,
    output key_state,
    output key_press,
    output key_release,
    output key_repeat
  );
endinterface

// File: rtl/key_chan_fsm.sv
// rtl/key_chan_fsm.sv - one key channel: 2-flop synchroniser, debounce FSM and repeat timer
module key_chan_fsm
  import key_pkg::*;
#(
  parameter int DEB_CNT    = 20,
  parameter int LONG_CNT   = 1000,
  parameter int REPEAT_CNT = 200,
  parameter int CNT_W      = 10,
  parameter bit REPEAT_EN  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CNT - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CNT - 1);

  logic             sync1;
  logic             ks;
  key_fsm_e         state;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous active-low key into the clock domain; reset reads as released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      ks    <= 1'b1;
    end else begin
      sync1 <= key_raw;
      ks    <= sync1;
    end
  end

  // Debounce/repeat FSM; all event outputs are registered one-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;
      case (state)
        IDLE: begin
          if (!ks) begin
            state <= PDEB;
            cnt   <= '0;
          end
        end
        PDEB: begin
          if (ks) begin
            // Low too short: treat as a glitch, no event
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state     <= HELD;
            key_press <= 1'b1;
            key_state <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (ks) begin
            state <= RDEB;
            cnt   <= '0;
          end else if (REPEAT_EN && (cnt == LONG_LAST)) begin
            state      <= RPT;
            key_repeat <= 1'b1;
            cnt        <= '0;
          end else if (cnt != LONG_LAST) begin
            // Saturate so a non-repeating key can be held indefinitely
            cnt <= cnt + 1'b1;
          end
        end
        RPT: begin
          if (ks) begin
            state <= RDEB;
            cnt   <= '0;
          end else if (cnt == RPT_LAST) begin
            key_repeat <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RDEB: begin
          if (!ks) begin
            // Bounce during release: key still held, long-press timing starts over
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state       <= IDLE;
            key_release <= 1'b1;
            key_state   <= 1'b0;
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Event pulses are single-cycle and mutually exclusive where consumers rely on it
  a_press_rel_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(key_press && key_release));
  a_press_rpt_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(key_press && key_repeat));
  a_press_width: assert property (@(posedge clk) disable iff (!rst_n)
    key_press |=> !key_press);
  a_release_width: assert property (@(posedge clk) disable iff (!rst_n)
    key_release |=> !key_release);
  a_repeat_width: assert property (@(posedge clk) disable iff (!rst_n)
    key_repeat |=> !key_repeat);
  a_state_rise: assert property (@(posedge clk) disable iff (!rst_n)
    $rose(key_state) |-> key_press);

endmodule

// File: rtl/key_filter_rpt.sv
// rtl/key_filter_rpt.sv - multi-channel key debouncer with press/release events and auto-repeat
module key_filter_rpt
  import key_pkg::*;
#(
  parameter int                 KEY_NUM    = 7,
  parameter int                 DEB_CNT    = 20,
  parameter int                 LONG_CNT   = 1000,
  parameter int                 REPEAT_CNT = 200,
  parameter logic [KEY_NUM-1:0] REPEAT_EN  = 7'b0011000
) (
  input  logic             clk,
  input  logic             rst_n,
  key_filter_rpt_if.slave  kif
);

  localparam int CNT_W = clog2(max3(DEB_CNT, LONG_CNT, REPEAT_CNT));

  logic [KEY_NUM-1:0] state_v;
  logic [KEY_NUM-1:0] press_v;
  logic [KEY_NUM-1:0] release_v;
  logic [KEY_NUM-1:0] repeat_v;

  // Reject timing parameters the FSM cannot honour
  if (DEB_CNT < 2 || LONG_CNT <= DEB_CNT || REPEAT_CNT < 2) begin : g_param_check
    $error("key_filter_rpt: need DEB_CNT>=2, LONG_CNT>DEB_CNT, REPEAT_CNT>=2");
  end

  // One independent conditioner per key
  for (genvar i = 0; i < KEY_NUM; i++) begin : g_chan
    key_chan_fsm #(
      .DEB_CNT    (DEB_CNT),
      .LONG_CNT   (LONG_CNT),
      .REPEAT_CNT (REPEAT_CNT),
      .CNT_W      (CNT_W),
      .REPEAT_EN  (REPEAT_EN[i])
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_raw     (kif.key_in[i]),
      .key_state   (state_v[i]),
      .key_press   (press_v[i]),
      .key_release (release_v[i]),
      .key_repeat  (repeat_v[i])
    );
  end

  assign kif.key_state   = state_v;
  assign kif.key_press   = press_v;
  assign kif.key_release = release_v;
  assign kif.key_repeat  = repeat_v;

endmodule

// File: tb/tb_key_filter_rpt.sv
// tb/tb_key_filter_rpt.sv - self-checking bench for key_filter_rpt with timed event scoreboard
module tb_key_filter_rpt;
  import key_pkg::*;

  localparam int KN   = 7;
  localparam int DEB  = 8;
  localparam int LONG = 64;
  localparam int REP  = 16;
  localparam int EV_PRESS   = 0;
  localparam int EV_RELEASE = 1;
  localparam int EV_REPEAT  = 2;
  localparam int FOREVER_CYC = 1 << 30;

  typedef struct {
    int ch;
    int kind;
    int cyc;
  } ev_t;

  typedef struct {
    logic [KN-1:0] mask;
    int            low_len;
    bit            pressed;
    int            n_rep;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   st_on [KN];
  int   st_off[KN];
  ev_t  exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_filter_rpt_if #(.KEY_NUM(KN)) kif ();

  key_filter_rpt #(
    .KEY_NUM    (KN),
    .DEB_CNT    (DEB),
    .LONG_CNT   (LONG),
    .REPEAT_CNT (REP),
    .REPEAT_EN  (7'b0011000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  function automatic string kname(input int k);
    case (k)
      EV_PRESS:   return "press";
      EV_RELEASE: return "release";
      default:    return "repeat";
    endcase
  endfunction

  function automatic vec_t mk(input logic [KN-1:0] m, input int len, input bit p, input int nrep);
    vec_t v;
    v.mask = m;
    v.low_len = len;
    v.pressed = p;
    v.n_rep = nrep;
    return v;
  endfunction

  task automatic push(input int c, input int k, input int t);
    ev_t e;
    e.ch = c;
    e.kind = k;
    e.cyc = t;
    exp_q.push_back(e);
  endtask

  task automatic check_pulse(input int c, input int k, input logic v);
    int idx;
    idx = -1;
    if (v === 1'b1) begin
      for (int i = 0; i < exp_q.size(); i++)
        if (exp_q[i].ch == c && exp_q[i].kind == k && exp_q[i].cyc == cyc) idx = i;
      n_chk++;
      if (idx < 0) begin
        n_fail++;
        $display("FAIL event ch%0d %s cyc=%0d actual=pulse required=none", c, kname(k), cyc);
      end else begin
        exp_q.delete(idx);
      end
    end
  endtask

  task automatic check_val(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic end_scen(input int id);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scen%0d missing_events actual=%0d required=0 first=ch%0d %s cyc=%0d",
               id, exp_q.size(), exp_q[0].ch, kname(exp_q[0].kind), exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  // Scoreboard monitor: every pulse must match a pending expectation; key_state follows the plan
  always @(negedge clk) begin
    logic [KN-1:0] exp_st;
    for (int c = 0; c < KN; c++) begin
      exp_st[c] = (cyc >= st_on[c]) && (cyc < st_off[c]);
      check_pulse(c, EV_PRESS,   kif.key_press[c]);
      check_pulse(c, EV_RELEASE, kif.key_release[c]);
      check_pulse(c, EV_REPEAT,  kif.key_repeat[c]);
    end
    n_chk++;
    if (kif.key_state !== exp_st) begin
      n_fail++;
      $display("FAIL key_state cyc=%0d actual=%b required=%b", cyc, kif.key_state, exp_st);
    end
  end

  initial begin
    vec_t vecs[7];
    int s;
    int g;
    int r;
    int t;

    for (int c = 0; c < KN; c++) begin
      st_on[c] = 0;
      st_off[c] = 0;
    end
    kif.key_in = '1;

    vecs[0] = mk(KN'(1) << KEY_DISP, 5, 1'b0, 0);
    vecs[1] = mk(KN'(1) << KEY_CLR, DEB - 1, 1'b0, 0);
    vecs[2] = mk(KN'(1) << KEY_SHIFT, DEB + 1, 1'b1, 0);
    vecs[3] = mk(KN'(1) << KEY_DISP, 30, 1'b1, 0);
    vecs[4] = mk(KN'(1) << KEY_INC, 210, 1'b1, 9);
    vecs[5] = mk(KN'(1) << KEY_DEC, 100, 1'b1, 2);
    vecs[6] = mk((KN'(1) << KEY_INC) | (KN'(1) << KEY_RUN) | (KN'(0) << KEY_MODE), 40, 1'b1, 0);

    repeat (3) @(negedge clk);
    check_val("reset_outputs",
              {kif.key_state, kif.key_press, kif.key_release, kif.key_repeat}, 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Table-driven presses: expected event times derived from low length and timing rules
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      s = cyc + 1;
      for (int c = 0; c < KN; c++) begin
        if (vecs[v].mask[c] && vecs[v].pressed) begin
          t = s + DEB + 2;
          push(c, EV_PRESS, t);
          for (int j = 0; j < vecs[v].n_rep; j++) push(c, EV_REPEAT, t + LONG + j * REP);
          push(c, EV_RELEASE, s + vecs[v].low_len + DEB + 2);
          st_on[c]  = t;
          st_off[c] = s + vecs[v].low_len + DEB + 2;
        end
      end
      kif.key_in = ~vecs[v].mask;
      repeat (vecs[v].low_len) @(negedge clk);
      kif.key_in = '1;
      repeat (DEB + 20) @(negedge clk);
      end_scen(v);
    end

    // Release bounce on KEY_DEC: no release, long-press timer restarts after the bounce
    @(negedge clk);
    s = cyc + 1;
    push(KEY_DEC, EV_PRESS, s + DEB + 2);
    st_on[KEY_DEC]  = s + DEB + 2;
    st_off[KEY_DEC] = FOREVER_CYC;
    kif.key_in[KEY_DEC] = 1'b0;
    repeat (40) @(negedge clk);
    kif.key_in[KEY_DEC] = 1'b1;
    repeat (3) @(negedge clk);
    kif.key_in[KEY_DEC] = 1'b0;
    g = cyc + 1;
    r = g + 87;
    for (t = g + 2 + LONG; t < r + 2; t += REP) push(KEY_DEC, EV_REPEAT, t);
    repeat (87) @(negedge clk);
    kif.key_in[KEY_DEC] = 1'b1;
    push(KEY_DEC, EV_RELEASE, r + DEB + 2);
    st_off[KEY_DEC] = r + DEB + 2;
    repeat (DEB + 20) @(negedge clk);
    end_scen(7);

    // Asynchronous reset while KEY_INC is auto-repeating, then a fresh press
    @(negedge clk);
    s = cyc + 1;
    push(KEY_INC, EV_PRESS, s + DEB + 2);
    push(KEY_INC, EV_REPEAT, s + DEB + 2 + LONG);
    st_on[KEY_INC]  = s + DEB + 2;
    st_off[KEY_INC] = FOREVER_CYC;
    kif.key_in[KEY_INC] = 1'b0;
    repeat (DEB + 2 + LONG + 1) @(negedge clk);
    #2;
    check_val("pre_reset_state_repeat", {62'd0, kif.key_state[KEY_INC], kif.key_repeat[KEY_INC]}, 64'd3);
    rst_n = 1'b0;
    for (int c = 0; c < KN; c++) begin
      st_on[c] = 0;
      st_off[c] = 0;
    end
    #1;
    check_val("async_reset_outputs",
              {kif.key_state, kif.key_press, kif.key_release, kif.key_repeat}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    s = cyc + 1;
    push(KEY_INC, EV_PRESS, s + DEB + 2);
    push(KEY_INC, EV_RELEASE, s + 20 + DEB + 2);
    st_on[KEY_INC]  = s + DEB + 2;
    st_off[KEY_INC] = s + 20 + DEB + 2;
    repeat (20) @(negedge clk);
    kif.key_in = '1;
    repeat (DEB + 20) @(negedge clk);
    end_scen(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
